// File: rtl/adc_frame_scheduler.sv
// Frame-rate scheduler for an MCP3202 SPI conversion engine: converts channel 0
// then channel 1 (or channel 0 only in mono) each frame and publishes 16-bit PCM.
module adc_frame_scheduler #(
    parameter int SAMPLE_DIV = 1125,
    parameter int TIMEOUT    = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mono,
    input  logic        clear_status,
    output logic        conv_start,
    output logic        conv_channel,
    input  logic        conv_done,
    input  logic [11:0] conv_data,
    output logic [15:0] sample_left,
    output logic [15:0] sample_right,
    output logic        sample_valid,
    output logic        overrun,
    output logic        timeout_err
);

    localparam int CNT_W  = $clog2(SAMPLE_DIV);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [WAIT_W-1:0] TO_LAST  = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_L,
        WAIT_L,
        START_R,
        WAIT_R,
        PUBLISH
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mono_q, mono_d;
    logic [15:0]       left_q, left_d;
    logic              conv_start_q, conv_start_d;
    logic              conv_channel_q, conv_channel_d;
    logic [15:0]       sample_left_q, sample_left_d;
    logic [15:0]       sample_right_q, sample_right_d;
    logic              sample_valid_q, sample_valid_d;
    logic              overrun_q, overrun_d;
    logic              timeout_err_q, timeout_err_d;

    logic        tick;
    logic        in_wait;
    logic        wait_expired;
    logic        conv_event;
    logic        timeout_hit;
    logic [15:0] capture_pcm;

    // Offset-binary to two's complement: flipping the MSB subtracts mid-scale.
    function automatic logic [15:0] pcm_of(input logic [11:0] d);
        return {~d[11], d[10:0], 4'b0000};
    endfunction

    always_comb begin
        tick         = enable && (frame_cnt_q == '0);
        frame_cnt_d  = (!enable || frame_cnt_q == '0) ? DIV_LAST : frame_cnt_q - CNT_W'(1);
        in_wait      = (state_q == WAIT_L) || (state_q == WAIT_R);
        wait_expired = (wait_cnt_q == TO_LAST);
        conv_event   = in_wait && (conv_done || wait_expired);
        timeout_hit  = in_wait && !conv_done && wait_expired;
        // A timed-out conversion reads as mid-scale, i.e. digital silence.
        capture_pcm  = conv_done ? pcm_of(conv_data) : 16'h0000;
        wait_cnt_d   = in_wait ? wait_cnt_q + WAIT_W'(1) : '0;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d        = state_q;
        mono_d         = mono_q;
        left_d         = left_q;
        conv_start_d   = 1'b0;
        conv_channel_d = conv_channel_q;
        sample_left_d  = sample_left_q;
        sample_right_d = sample_right_q;
        sample_valid_d = 1'b0;
        overrun_d      = overrun_q && !clear_status;
        timeout_err_d  = timeout_err_q && !clear_status;

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d        = START_L;
                    mono_d         = mono;
                    conv_start_d   = 1'b1;
                    conv_channel_d = 1'b0;
                end
            end
            START_L: state_d = WAIT_L;
            WAIT_L: begin
                if (conv_event) begin
                    if (mono_q) begin
                        state_d        = PUBLISH;
                        sample_left_d  = capture_pcm;
                        sample_right_d = capture_pcm;
                        sample_valid_d = 1'b1;
                    end else begin
                        state_d        = START_R;
                        left_d         = capture_pcm;
                        conv_start_d   = 1'b1;
                        conv_channel_d = 1'b1;
                    end
                end
            end
            START_R: state_d = WAIT_R;
            WAIT_R: begin
                if (conv_event) begin
                    state_d        = PUBLISH;
                    sample_left_d  = left_q;
                    sample_right_d = capture_pcm;
                    sample_valid_d = 1'b1;
                end
            end
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Set events override a simultaneous clear.
        if (tick && state_q != IDLE) overrun_d = 1'b1;
        if (timeout_hit)             timeout_err_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            frame_cnt_q    <= DIV_LAST;
            wait_cnt_q     <= '0;
            mono_q         <= 1'b0;
            left_q         <= '0;
            conv_start_q   <= 1'b0;
            conv_channel_q <= 1'b0;
            sample_left_q  <= '0;
            sample_right_q <= '0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_cnt_q    <= frame_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            mono_q         <= mono_d;
            left_q         <= left_d;
            conv_start_q   <= conv_start_d;
            conv_channel_q <= conv_channel_d;
            sample_left_q  <= sample_left_d;
            sample_right_q <= sample_right_d;
            sample_valid_q <= sample_valid_d;
            overrun_q      <= overrun_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign conv_start   = conv_start_q;
    assign conv_channel = conv_channel_q;
    assign sample_left  = sample_left_q;
    assign sample_right = sample_right_q;
    assign sample_valid = sample_valid_q;
    assign overrun      = overrun_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// Bench for adc_frame_scheduler: an SPI-engine model answers conversion requests
// and pushes expected PCM pairs into a scoreboard checked at every publish.
module tb_adc_frame_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        mono;
    logic        clear_status;
    logic        conv_start;
    logic        conv_channel;
    logic        conv_done;
    logic [11:0] conv_data;
    logic [15:0] sample_left;
    logic [15:0] sample_right;
    logic        sample_valid;
    logic        overrun;
    logic        timeout_err;

    adc_frame_scheduler #(.SAMPLE_DIV(16), .TIMEOUT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .mono        (mono),
        .clear_status(clear_status),
        .conv_start  (conv_start),
        .conv_channel(conv_channel),
        .conv_done   (conv_done),
        .conv_data   (conv_data),
        .sample_left (sample_left),
        .sample_right(sample_right),
        .sample_valid(sample_valid),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb[$];

    // Engine model configuration (written by the main sequence only).
    int          eng_delay  = 3;
    bit          eng_silent = 1'b0;
    logic [11:0] left_data  = 12'hFFF;
    logic [11:0] right_data = 12'h000;
    logic [11:0] inject_data = 12'h000;
    int          inject_req = 0;

    // Engine model state.
    int          inject_ack = 0;
    int          pend_cnt   = 0;
    logic        pend_ch    = 1'b0;
    logic [11:0] pend_data  = '0;
    logic [15:0] left_exp   = '0;
    int          start_cnt  = 0;
    int          valid_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] expect_pcm(input logic [11:0] d);
        int v;
        v = (int'(d) - 2048) * 16;
        return v[15:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string tag, output int at);
        int n = 0;
        do begin
            step();
            n++;
        end while (!conv_start && n < 200);
        check({tag, "_seen"}, 32'(conv_start), 32'd1);
        at = cyc;
    endtask

    task automatic wait_valid(input string tag, output int at);
        int n = 0;
        do begin
            step();
            n++;
        end while (!sample_valid && n < 200);
        check({tag, "_seen"}, 32'(sample_valid), 32'd1);
        at = cyc;
    endtask

    // SPI engine model: answers each request eng_delay cycles later.
    initial begin
        conv_done = 1'b0;
        conv_data = '0;
        forever begin
            step();
            conv_done = 1'b0;
            if (inject_ack != inject_req) begin
                inject_ack = inject_req;
                conv_done  = 1'b1;
                conv_data  = inject_data;
            end
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    conv_done = 1'b1;
                    conv_data = pend_data;
                    if (!pend_ch && mono)
                        sb.push_back({expect_pcm(pend_data), expect_pcm(pend_data)});
                    else if (!pend_ch)
                        left_exp = expect_pcm(pend_data);
                    else
                        sb.push_back({left_exp, expect_pcm(pend_data)});
                end
            end
            if (conv_start) begin
                start_cnt++;
                if (!eng_silent) begin
                    pend_cnt  = eng_delay;
                    pend_ch   = conv_channel;
                    pend_data = conv_channel ? right_data : left_data;
                end
            end
        end
    end

    // Publish monitor, sampled on the falling edge.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (sample_valid) begin
                valid_cnt++;
                check("sb_pending", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("pub_left", 32'(sample_left), 32'(e[31:16]));
                    check("pub_right", 32'(sample_right), 32'(e[15:0]));
                end
            end
        end
    end

    initial begin
        int e0, t, s, s0, r0, vc;
        logic [15:0] sl, sr;

        reset = 1'b1;
        enable = 1'b0;
        mono = 1'b0;
        clear_status = 1'b0;
        repeat (3) step();
        check("rst_ctrl", {27'd0, conv_start, conv_channel, sample_valid, overrun, timeout_err}, 32'd0);
        check("rst_left", 32'(sample_left), 32'd0);
        check("rst_right", 32'(sample_right), 32'd0);

        reset = 1'b0;
        step();
        enable = 1'b1;
        e0 = cyc;

        // Stereo: left 0xFFF, right 0x000.
        wait_start("start_l1", t);
        check("start_l1_cyc", 32'(t - e0), 32'd16);
        check("start_l1_ch", 32'(conv_channel), 32'd0);
        wait_start("start_r1", t);
        check("start_r1_cyc", 32'(t - e0), 32'd20);
        check("start_r1_ch", 32'(conv_channel), 32'd1);
        wait_valid("pub1", t);
        check("pub1_cyc", 32'(t - e0), 32'd24);
        step();
        check("valid_one_cycle", 32'(sample_valid), 32'd0);
        s0 = start_cnt;
        wait_start("start_l2", t);
        check("start_l2_cyc", 32'(t - e0), 32'd32);
        wait_valid("pub2", t);
        check("pub2_cyc", 32'(t - e0), 32'd40);
        check("stereo_starts", 32'(start_cnt - s0), 32'd2);

        // Mono: data 0x123 on both outputs.
        mono = 1'b1;
        left_data = 12'h123;
        s0 = start_cnt;
        wait_valid("mono1", t);
        check("mono1_cyc", 32'(t - e0), 32'd52);
        check("mono1_starts", 32'(start_cnt - s0), 32'd1);
        check("mono1_ch", 32'(conv_channel), 32'd0);
        s0 = start_cnt;
        wait_valid("mono2", t);
        check("mono2_starts", 32'(start_cnt - s0), 32'd1);
        check("mono2_ch", 32'(conv_channel), 32'd0);

        // Silent engine: both conversions time out and the frame overruns.
        mono = 1'b0;
        eng_silent = 1'b1;
        sb.push_back(32'h0000_0000);
        wait_start("to_start", s);
        repeat (8) step();
        check("to_not_yet", 32'(timeout_err), 32'd0);
        step();
        check("to_set", 32'(timeout_err), 32'd1);
        check("to_start_r", 32'(conv_start), 32'd1);
        check("to_start_r_ch", 32'(conv_channel), 32'd1);
        check("ovr_not_yet", 32'(overrun), 32'd0);
        wait_valid("to_pub", t);
        check("to_pub_cyc", 32'(t - s), 32'd18);
        check("ovr_set", 32'(overrun), 32'd1);
        eng_silent = 1'b0;
        left_data  = 12'h800;
        right_data = 12'hABC;
        wait_start("ovr_skip", t);
        check("ovr_skip_cyc", 32'(t - s), 32'd32);
        wait_valid("ovr_pub", t);
        check("ovr_pub_cyc", 32'(t - s), 32'd40);
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        check("clr_overrun", 32'(overrun), 32'd0);
        check("clr_timeout", 32'(timeout_err), 32'd0);

        // conv_done while IDLE must be ignored.
        sl = sample_left;
        sr = sample_right;
        vc = valid_cnt;
        inject_data = 12'hFFF;
        inject_req++;
        repeat (4) step();
        check("idle_done_valid", 32'(valid_cnt - vc), 32'd0);
        check("idle_done_left", 32'(sample_left), 32'(sl));
        check("idle_done_right", 32'(sample_right), 32'(sr));

        // Reset during WAIT_R with conv_done arriving the cycle after.
        wait_start("rst_l", t);
        wait_start("rst_r", t);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        r0 = cyc;
        vc = valid_cnt;
        check("rst_mid_left", 32'(sample_left), 32'd0);
        check("rst_mid_right", 32'(sample_right), 32'd0);
        check("rst_mid_ctrl", {29'd0, conv_start, conv_channel, sample_valid}, 32'd0);
        wait_start("rst_next", t);
        check("rst_next_cyc", 32'(t - r0), 32'd16);
        check("rst_next_ch", 32'(conv_channel), 32'd0);
        check("rst_no_pub", 32'(valid_cnt - vc), 32'd0);
        sb.delete();
        wait_valid("recover", t);
        check("recover_cyc", 32'(t - r0), 32'd24);
        step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
